// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives a 1-cycle-latency instruction memory,
// and presents {pc, instr, valid} to IF/ID with a 1-entry skid buffer for stalls.
module if_fetch_stage #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int unsigned     PC_STEP  = 4
) (
    input  logic            clk,
    input  logic            rest,
    input  logic            stall,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_en,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            if_valid,
    output logic [XLEN-1:0] if_pc,
    output logic [XLEN-1:0] if_instr
);

    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);
    localparam logic [XLEN-1:0] STEP       = XLEN'(PC_STEP);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_pkt_t;

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            req_q, req_d;
    logic [XLEN-1:0] req_pc_q, req_pc_d;
    fetch_pkt_t      skid_q, skid_d;

    logic [XLEN-1:0] target_c;
    logic            resp_c;
    logic            skid_v_c;

    // Word-aligned redirect target; a redirect kills the response landing this cycle.
    always_comb begin
        target_c = redirect_pc & ALIGN_MASK;
        resp_c   = req_q & ~redirect;
        skid_v_c = (state_q == HOLD);
    end

    // Next-state, request issue and presentation.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        req_d     = 1'b0;
        req_pc_d  = req_pc_q;
        skid_d    = skid_q;
        imem_en   = 1'b0;
        imem_addr = redirect ? target_c : pc_q;
        if_valid  = 1'b0;
        if_pc     = '0;
        if_instr  = '0;

        case (state_q)
            BOOT: begin
                state_d = RUN;
            end
            RUN: begin
                imem_en = redirect | ~stall;
                if (resp_c) begin
                    if_valid = 1'b1;
                    if_pc    = req_pc_q;
                    if_instr = imem_rdata;
                    if (stall) begin
                        state_d      = HOLD;
                        skid_d.pc    = req_pc_q;
                        skid_d.instr = imem_rdata;
                    end
                end
            end
            HOLD: begin
                imem_en = redirect | ~stall;
                // Skid contents are wrong-path once a redirect arrives.
                if (skid_v_c && !redirect) begin
                    if_valid = 1'b1;
                    if_pc    = skid_q.pc;
                    if_instr = skid_q.instr;
                end
                if (redirect || !stall) begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase

        if (imem_en) begin
            pc_d = imem_addr + STEP;
        end
        req_d    = imem_en;
        req_pc_d = imem_addr;
    end

    always_ff @(posedge clk or negedge rest) begin
        if (!rest) begin
            state_q  <= BOOT;
            pc_q     <= RESET_PC;
            req_q    <= 1'b0;
            req_pc_q <= '0;
            skid_q   <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            req_q    <= req_d;
            req_pc_q <= req_pc_d;
            skid_q   <= skid_d;
        end
    end

endmodule
